// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Front-end driver for the 4x4 systolic multiplier array. Matrix A (row
// operands) and matrix B (column operands) are loaded one element at a time
// through a word-write port while idle. A start request produces a one-cycle
// clear pulse for the array accumulators. It then streams the diagonally skewed
// operands on the array's left and top edges, and finally pulses done once the
// array holds C = A x B.
//
// Ports:
//   clk_i      clock, all logic on the rising edge
//   rst_i      synchronous active-high reset (clears FSM and operand storage)
//   wr_en_i    write one matrix element this cycle (honoured only when idle)
//   wr_sel_i   0 = matrix A, 1 = matrix B
//   wr_row_i   element row index
//   wr_col_i   element column index
//   wr_data_i  element value
//   start_i    begin a multiply run (honoured only when idle)
//   busy_o     high from CLEAR through DONE
//   arr_clr_o  one-cycle clear for the array accumulators
//   left_o     lane r at [r*DW +: DW], feeds array left input of row r
//   up_o       lane c at [c*DW +: DW], feeds array top input of column c
//   valid_o    high during every STREAM cycle
//   done_o     one-cycle pulse, array results are final
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int DW = 32,
  parameter int N  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic            wr_sel_i,
  input  logic [1:0]      wr_row_i,
  input  logic [1:0]      wr_col_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            arr_clr_o,
  output logic [N*DW-1:0] left_o,
  output logic [N*DW-1:0] up_o,
  output logic            valid_o,
  output logic            done_o
);

  // The stream phase runs t = 0 .. 3N-3. The last N-1 cycles are all-zero
  // flush cycles that let the final operands walk to the far corner.
  localparam int            TW     = $clog2(3*N-2);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [TW-1:0]   r_t;
  logic [TW-1:0]   w_tNext;
  logic            w_streamNext;

  logic [DW-1:0]   r_matA [N][N];
  logic [DW-1:0]   r_matB [N][N];

  logic [N*DW-1:0] r_left;
  logic [N*DW-1:0] r_up;
  logic [N*DW-1:0] w_leftNext;
  logic [N*DW-1:0] w_upNext;

  logic            r_busy;
  logic            r_clr;
  logic            r_valid;
  logic            r_done;

  // Operand storage. Writes only land while idle, so the operands cannot
  // change underneath a run. A write in the same idle cycle as start_i
  // commits at that edge. The lanes for t=0 are computed one cycle later,
  // during CLEAR, so that run already sees the new value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_matA <= '{default: '0};
      r_matB <= '{default: '0};
    end else if (wr_en_i && (r_state == S_IDLE)) begin
      if (wr_sel_i) begin
        r_matB[wr_row_i][wr_col_i] <= wr_data_i;
      end else begin
        r_matA[wr_row_i][wr_col_i] <= wr_data_i;
      end
    end
  end

  // State and stream-cycle counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_stateNext;
      r_t     <= w_tNext;
    end
  end

  // Next-state logic. The counter is reloaded to zero whenever it is not
  // actively stepping through the stream, so every run starts cleanly at t=0.
  always_comb begin
    w_stateNext = r_state;
    w_tNext     = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_stateNext = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_stateNext = S_STREAM;
      end
      S_STREAM: begin
        if (r_t == T_LAST) begin
          w_stateNext = S_DONE;
        end else begin
          w_tNext = r_t + 1'b1;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign w_streamNext = (w_stateNext == S_STREAM);

  // Skew generation. All outputs are registered, so the lanes are computed
  // from the state and counter the machine is about to enter. Row lane g
  // and column lane g share the same diagonal offset t-g. The row lane picks
  // A[g][t-g] and the column lane picks B[t-g][g]. Lanes stay zero outside
  // the 0..N-1 window and whenever the next state is not STREAM.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [TW-1:0] w_off;
    logic          w_hit;

    assign w_off = w_tNext - TW'(g);
    assign w_hit = w_streamNext && (w_tNext >= TW'(g)) && (w_off < TW'(N));

    assign w_leftNext[g*DW +: DW] = w_hit ? r_matA[g][w_off[1:0]] : '0;
    assign w_upNext[g*DW +: DW]   = w_hit ? r_matB[w_off[1:0]][g] : '0;
  end

  // Output registers. The status flags decode the upcoming state, so each
  // flag lines up with the cycle in which the FSM sits in that state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_left  <= '0;
      r_up    <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_left  <= w_leftNext;
      r_up    <= w_upNext;
      r_busy  <= (w_stateNext != S_IDLE);
      r_clr   <= (w_stateNext == S_CLEAR);
      r_valid <= w_streamNext;
      r_done  <= (w_stateNext == S_DONE);
    end
  end

  assign left_o    = r_left;
  assign up_o      = r_up;
  assign busy_o    = r_busy;
  assign arr_clr_o = r_clr;
  assign valid_o   = r_valid;
  assign done_o    = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder. It loads operand matrices, runs
// multiplies and checks the clear/valid/done timing and the skewed lane
// contents against hand-computed values. It also drives a small cycle model
// of the 4x4 systolic array from the lanes to confirm the product.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk_i;
  logic            rst_i;
  logic            wr_en_i;
  logic            wr_sel_i;
  logic [1:0]      wr_row_i;
  logic [1:0]      wr_col_i;
  logic [DW-1:0]   wr_data_i;
  logic            start_i;
  logic            busy_o;
  logic            arr_clr_o;
  logic [N*DW-1:0] left_o;
  logic [N*DW-1:0] up_o;
  logic            valid_o;
  logic            done_o;

  int checkCount;
  int errorCount;

  // Per-run capture: lanes by stream cycle, plus event timing relative to E0.
  logic [DW-1:0] capL [10][N];
  logic [DW-1:0] capU [10][N];
  int            clrCount, clrAt, doneCount, doneAt, validCount;
  logic          busyAfter;

  // Systolic array model: accumulators plus the right/down pipeline registers.
  logic [DW-1:0] acc  [N][N];
  logic [DW-1:0] aReg [N][N];
  logic [DW-1:0] bReg [N][N];

  systolic_feeder #(.DW(DW), .N(N)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_sel_i  (wr_sel_i),
    .wr_row_i  (wr_row_i),
    .wr_col_i  (wr_col_i),
    .wr_data_i (wr_data_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .arr_clr_o (arr_clr_o),
    .left_o    (left_o),
    .up_o      (up_o),
    .valid_o   (valid_o),
    .done_o    (done_o)
  );

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends on its own.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the expected one and tally the result.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int idx);
    return v[idx*DW +: DW];
  endfunction

  // Write a single matrix element while idle.
  task automatic writeElem(input logic sel, input int row, input int col,
                           input logic [DW-1:0] data);
    wr_en_i   = 1'b1;
    wr_sel_i  = sel;
    wr_row_i  = 2'(row);
    wr_col_i  = 2'(col);
    wr_data_i = data;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc[i][j]  = '0;
        aReg[i][j] = '0;
        bReg[i][j] = '0;
      end
    end
  endtask

  // One array cycle. Each PE multiplies the operands arriving from its left
  // and top neighbours, then passes them on right and down.
  task automatic stepModel();
    logic [DW-1:0] aNew [N][N];
    logic [DW-1:0] bNew [N][N];
    logic [DW-1:0] aIn, bIn;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        aIn = (j == 0) ? lane(left_o, i) : aReg[i][j-1];
        bIn = (i == 0) ? lane(up_o, j)   : bReg[i-1][j];
        acc[i][j]  = acc[i][j] + aIn * bIn;
        aNew[i][j] = aIn;
        bNew[i][j] = bIn;
      end
    end
    aReg = aNew;
    bReg = bNew;
  endtask

  // Pulse start (plus any write the caller has already set up), then watch
  // cycles E0+1 .. E0+12 and record timing, lanes and the array model.
  // wrAtK > 0 attempts a write of 0xDEAD to A[0][0] during cycle E0+wrAtK.
  task automatic applyStimulus(input int wrAtK);
    clrCount = 0; clrAt = -1; doneCount = 0; doneAt = -1; validCount = 0;
    for (int t = 0; t < 10; t++) begin
      for (int l = 0; l < N; l++) begin
        capL[t][l] = 'x;
        capU[t][l] = 'x;
      end
    end
    clearModel();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wr_en_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (arr_clr_o) begin
        clrCount++;
        clrAt = k;
        clearModel();
      end
      if (done_o) begin
        doneCount++;
        doneAt = k;
      end
      if (valid_o) begin
        validCount++;
        if (k >= 2 && k <= 11) begin
          for (int l = 0; l < N; l++) begin
            capL[k-2][l] = lane(left_o, l);
            capU[k-2][l] = lane(up_o, l);
          end
        end
        stepModel();
      end
      if (k == wrAtK) begin
        wr_en_i   = 1'b1;
        wr_sel_i  = 1'b0;
        wr_row_i  = 2'd0;
        wr_col_i  = 2'd0;
        wr_data_i = 32'hDEAD;
      end else begin
        wr_en_i = 1'b0;
      end
      tick();
    end
    wr_en_i   = 1'b0;
    busyAfter = busy_o;
  endtask

  initial begin
    int            busySeen, doneSeen, nonZero, clrN, doneN, extraDone;
    int            clrPos [3];
    int            donePos [2];
    bit            idleReached;
    logic [DW-1:0] expV [4];

    checkCount = 0;
    errorCount = 0;
    rst_i      = 1'b1;
    wr_en_i    = 1'b0;
    wr_sel_i   = 1'b0;
    wr_row_i   = 2'd0;
    wr_col_i   = 2'd0;
    wr_data_i  = '0;
    start_i    = 1'b0;

    // 1. Reset then idle.
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("rst_busy",  32'(busy_o),    32'd0);
    checkOutput("rst_clr",   32'(arr_clr_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o),   32'd0);
    checkOutput("rst_done",  32'(done_o),    32'd0);
    checkOutput("rst_left",  32'(|left_o),   32'd0);
    checkOutput("rst_up",    32'(|up_o),     32'd0);
    busySeen = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_o || valid_o || arr_clr_o || done_o) busySeen++;
      tick();
    end
    checkOutput("idle_quiet", 32'(busySeen), 32'd0);

    // 2. Identity x B, B[i][j] = 4i+j+1.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        writeElem(1'b0, i, j, (i == j) ? 32'd1 : 32'd0);
        writeElem(1'b1, i, j, 32'(4*i + j + 1));
      end
    end
    applyStimulus(0);
    checkOutput("id_clr_count",   32'(clrCount),   32'd1);
    checkOutput("id_clr_at",      32'(clrAt),      32'd1);
    checkOutput("id_valid_count", 32'(validCount), 32'd10);
    checkOutput("id_done_count",  32'(doneCount),  32'd1);
    checkOutput("id_done_at",     32'(doneAt),     32'd12);
    checkOutput("id_busy_after",  32'(busyAfter),  32'd0);
    checkOutput("id_up2_t2", capU[2][2], 32'd3);
    checkOutput("id_up2_t3", capU[3][2], 32'd7);
    checkOutput("id_up2_t4", capU[4][2], 32'd11);
    checkOutput("id_up2_t5", capU[5][2], 32'd15);
    checkOutput("id_up2_t1", capU[1][2], 32'd0);
    checkOutput("id_left0_t0", capL[0][0], 32'd1);
    checkOutput("id_left3_t6", capL[6][3], 32'd1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        checkOutput($sformatf("id_c%0d%0d", i, j), acc[i][j], 32'(4*i + j + 1));
      end
    end

    // 3. Skew check with A[i][j] = 0x100*i + j.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        writeElem(1'b0, i, j, 32'(256*i + j));
      end
    end
    applyStimulus(0);
    expV = '{32'h003, 32'h102, 32'h201, 32'h300};
    for (int l = 0; l < N; l++) begin
      checkOutput($sformatf("skew_t3_l%0d", l), capL[3][l], expV[l]);
    end
    expV = '{32'h0, 32'h0, 32'h0, 32'h303};
    for (int l = 0; l < N; l++) begin
      checkOutput($sformatf("skew_t6_l%0d", l), capL[6][l], expV[l]);
    end
    nonZero = 0;
    for (int t = 7; t <= 9; t++) begin
      for (int l = 0; l < N; l++) begin
        if (capL[t][l] !== '0 || capU[t][l] !== '0) nonZero++;
      end
    end
    checkOutput("skew_flush_zero", 32'(nonZero), 32'd0);
    checkOutput("skew_up0_t0", capU[0][0], 32'd1);

    // 4. Write lockout during a run, then write together with start.
    writeElem(1'b0, 0, 0, 32'h77);
    applyStimulus(5);
    checkOutput("lock_run1_l0", capL[0][0], 32'h77);
    applyStimulus(0);
    checkOutput("lock_run2_l0", capL[0][0], 32'h77);
    wr_en_i   = 1'b1;
    wr_sel_i  = 1'b0;
    wr_row_i  = 2'd0;
    wr_col_i  = 2'd0;
    wr_data_i = 32'd5;
    applyStimulus(0);
    checkOutput("wr_with_start_l0", capL[0][0], 32'd5);
    checkOutput("wr_with_start_done", 32'(doneAt), 32'd12);

    // 5. Reset in the middle of a run (at stream cycle t=4, i.e. E0+6).
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    checkOutput("mid_pre_valid", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("mid_busy",  32'(busy_o),  32'd0);
    checkOutput("mid_valid", 32'(valid_o), 32'd0);
    checkOutput("mid_left",  32'(|left_o), 32'd0);
    checkOutput("mid_up",    32'(|up_o),   32'd0);
    doneSeen = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_o || busy_o) doneSeen++;
      tick();
    end
    checkOutput("mid_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(0);
    nonZero = 0;
    for (int t = 0; t < 10; t++) begin
      for (int l = 0; l < N; l++) begin
        if (capL[t][l] !== '0 || capU[t][l] !== '0) nonZero++;
      end
    end
    checkOutput("mid_after_valid", 32'(validCount), 32'd10);
    checkOutput("mid_after_zero",  32'(nonZero),    32'd0);

    // 6. Back-to-back runs with start held high.
    clrN  = 0;
    doneN = 0;
    clrPos  = '{-1, -1, -1};
    donePos = '{-1, -1};
    start_i = 1'b1;
    tick();
    for (int k = 1; k <= 27; k++) begin
      if (arr_clr_o) begin
        if (clrN < 3) clrPos[clrN] = k;
        clrN++;
      end
      if (done_o) begin
        if (doneN < 2) donePos[doneN] = k;
        doneN++;
      end
      tick();
    end
    start_i = 1'b0;
    checkOutput("b2b_clr_count",  32'(clrN),       32'd3);
    checkOutput("b2b_clr0",       32'(clrPos[0]),  32'd1);
    checkOutput("b2b_clr1",       32'(clrPos[1]),  32'd14);
    checkOutput("b2b_clr2",       32'(clrPos[2]),  32'd27);
    checkOutput("b2b_done_count", 32'(doneN),      32'd2);
    checkOutput("b2b_done0",      32'(donePos[0]), 32'd12);
    checkOutput("b2b_done1",      32'(donePos[1]), 32'd25);
    extraDone   = 0;
    idleReached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_o) extraDone++;
      if (!busy_o) begin
        idleReached = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("b2b_idle_reached", 32'(idleReached), 32'd1);
    checkOutput("b2b_last_done",    32'(extraDone),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Front-end driver for the 4x4 systolic multiplier array. It stores matrix A (row operands) and matrix B (column operands) through a word-write port. On start it issues a clear pulse to the array, then emits the diagonally skewed operand streams on the array's left and top edges. It pulses done when the array's accumulators hold the final C = A x B. It is the transmitting end of the array's left/up operand interface and replaces hand-built skewed stimulus.

Parameters:
DW, 32, operand width per lane
N, 4, array dimension (rows = cols = lanes); 4 is the only configuration the array supports

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
wr_en_i  in  1  write one matrix element this cycle
wr_sel_i  in  1  0 = matrix A, 1 = matrix B
wr_row_i  in  2  element row index
wr_col_i  in  2  element column index
wr_data_i  in  DW  element value
start_i  in  1  begin a multiply run
busy_o  out  1  high from CLEAR through DONE
arr_clr_o  out  1  one-cycle clear for array accumulators (drive array reset as its polarity requires)
left_o  out  N*DW  lane r at bits [r*DW +: DW]; feeds array left input of row r
up_o  out  N*DW  lane c at bits [c*DW +: DW]; feeds array top input of column c
valid_o  out  1  high during every STREAM cycle
done_o  out  1  one-cycle pulse: array results final

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, cycle counter 0, all A/B storage cleared to 0. Outputs after reset: busy_o, arr_clr_o, valid_o, done_o = 0; left_o, up_o = 0. Reset overrides everything, including mid-run: the run is abandoned and no done_o is issued.
- Storage: 2 x N x N registers of DW bits. A write commits at the edge where wr_en_i=1, but only if state is IDLE. Writes in any other state are ignored, so operands stay stable during a run. A write and start_i in the same IDLE cycle are both accepted, and the new value is used by that run. Storage persists across runs.
- FSM transitions:
  IDLE -> CLEAR when start_i=1; start_i is ignored in all other states.
  CLEAR lasts 1 cycle: arr_clr_o=1, lanes 0. Then -> STREAM with t=0.
  STREAM lasts t = 0 .. 3N-3 (10 cycles for N=4): valid_o=1. Then -> DONE.
  DONE lasts 1 cycle: done_o=1, lanes 0. Then -> IDLE.
- Skew rule, all outputs registered, shown during STREAM cycle t:
  left lane r = A[r][t-r] if 0 <= t-r < N, else 0.
  up lane c = B[t-c][c] if 0 <= t-c < N, else 0.
  Cycles t >= 2N-1 carry all zeros. These are flush cycles that let the last operands propagate through the array.
- Latency: start_i sampled at edge E0 gives CLEAR in cycle E0+1, STREAM t=0 in cycle E0+2, last STREAM in cycle E0+11, done_o in cycle E0+12, and IDLE (busy_o=0) in cycle E0+13. A new start_i is accepted from that cycle on.
- No arithmetic is done here. Values pass through unmodified at DW bits, with no sign handling.
- Outside STREAM, left_o and up_o are forced to 0, so the array never accumulates stale data.

Test Plan:
1. Reset then idle: hold rst_i 2 cycles -> all outputs 0; start_i never asserted -> busy_o stays 0 for 20 cycles.
2. Identity x B: A=I, B[i][j]=4i+j+1, start -> arr_clr_o=1 for exactly 1 cycle; lane sequences match the skew rule (up lane 2 at t=2..5 = 3,7,11,15); done_o at E0+12; the array model yields C == B.
3. Skew check: A[i][j]=0x100*i+j. At t=3, left lanes 0..3 = 0x003, 0x102, 0x201, 0x300. At t=6 only lane 3 = 0x303. At t=7..9 all lanes = 0.
4. Write lockout: write A[0][0]=0xDEAD during STREAM -> ignored; rerun shows the old A[0][0]. A write of 5 in the same cycle as start_i -> 5 appears on left lane 0 at t=0.
5. Reset mid-run: assert rst_i at t=4 -> next cycle busy_o=0, lanes 0, no done_o; a subsequent start streams all zeros (storage cleared).
6. Back-to-back runs: start_i held high continuously -> second CLEAR begins the cycle after IDLE is re-entered (period 13 cycles); done_o pulses exactly once per run.
